// File: rtl/bilinear_demosaicing_3x3_pkg.sv
// Shared constants for the bilinear demosaicing datapath: Bayer patterns,
// CFA site encoding and 3x3 window element indices.
package bilinear_demosaicing_3x3_pkg;

    localparam logic [1:0] PAT_RGGB = 2'd0;
    localparam logic [1:0] PAT_GRBG = 2'd1;
    localparam logic [1:0] PAT_GBRG = 2'd2;
    localparam logic [1:0] PAT_BGGR = 2'd3;

    // Encoding is {row_site, col_site}, so decode is a plain XOR with the pattern.
    typedef enum logic [1:0] {
        SITE_R  = 2'd0,
        SITE_GR = 2'd1,
        SITE_GB = 2'd2,
        SITE_B  = 2'd3
    } site_e;

    // Control values held after reset, matching the CSR block reset values.
    localparam logic       RST_EN      = 1'b1;
    localparam logic [1:0] RST_PATTERN = PAT_BGGR;

    localparam int K_NW     = 0;
    localparam int K_N      = 1;
    localparam int K_NE     = 2;
    localparam int K_W      = 3;
    localparam int K_CENTRE = 4;
    localparam int K_E      = 5;
    localparam int K_SW     = 6;
    localparam int K_S      = 7;
    localparam int K_SE     = 8;

    function automatic site_e site_decode(input logic       row_par,
                                          input logic       col_par,
                                          input logic [1:0] pattern);
        return site_e'({row_par ^ pattern[1], col_par ^ pattern[0]});
    endfunction

endpackage

// File: rtl/bilinear_demosaicing_3x3_bayer_phase.sv
// Row/column parity tracker, per-frame control latching and CFA site decode
// for the window currently offered on the input.
module bilinear_demosaicing_3x3_bayer_phase
    import bilinear_demosaicing_3x3_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       i_hs,
    input  logic       i_tuser,
    input  logic       i_tlast,
    input  logic       i_en,
    input  logic [1:0] i_pattern,
    output site_e      o_site,
    output logic       o_en
);

    logic       r_en;
    logic [1:0] r_pattern;
    logic       r_row_par;
    logic       r_col_par;

    logic       w_en;
    logic [1:0] w_pattern;
    logic       w_row_par;
    logic       w_col_par;

    // A start-of-frame window uses its own control and restarts the phase at (0,0).
    always_comb begin
        w_en      = r_en;
        w_pattern = r_pattern;
        w_row_par = r_row_par;
        w_col_par = r_col_par;
        if (i_tuser) begin
            w_en      = i_en;
            w_pattern = i_pattern;
            w_row_par = 1'b0;
            w_col_par = 1'b0;
        end
    end

    assign o_site = site_decode(w_row_par, w_col_par, w_pattern);
    assign o_en   = w_en;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_en      <= RST_EN;
            r_pattern <= RST_PATTERN;
            r_row_par <= 1'b0;
            r_col_par <= 1'b0;
        end else if (i_hs) begin
            r_en      <= w_en;
            r_pattern <= w_pattern;
            if (i_tlast) begin
                r_row_par <= ~w_row_par;
                r_col_par <= 1'b0;
            end else begin
                r_row_par <= w_row_par;
                r_col_par <= ~w_col_par;
            end
        end
    end

endmodule

// File: rtl/bilinear_demosaicing_3x3_interp.sv
// Bilinear demosaicing datapath: 3x3 Bayer window in, one RGB pixel out,
// elastic two-stage pipeline. Define BILINEAR_DEMOSAICING_3X3_ROUND_EN for round-half-up averages.
module bilinear_demosaicing_3x3_interp
    import bilinear_demosaicing_3x3_pkg::*;
#(
    parameter int PX_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [1:0]            pattern_i,
    input  logic [9*PX_WIDTH-1:0] win_tdata_i,
    input  logic                  win_tvalid_i,
    output logic                  win_tready_o,
    input  logic                  win_tuser_i,
    input  logic                  win_tlast_i,
    output logic [3*PX_WIDTH-1:0] rgb_tdata_o,
    output logic                  rgb_tvalid_o,
    input  logic                  rgb_tready_i,
    output logic                  rgb_tuser_o,
    output logic                  rgb_tlast_o
);

    localparam int W4 = PX_WIDTH + 2;
    localparam int W2 = PX_WIDTH + 1;

    // Four PX_WIDTH terms fit W4 bits; adding 2 before the shift still fits.
    function automatic logic [PX_WIDTH-1:0] div4(input logic [W4-1:0] s);
`ifdef BILINEAR_DEMOSAICING_3X3_ROUND_EN
        return PX_WIDTH'((s + W4'(2)) >> 2);
`else
        return PX_WIDTH'(s >> 2);
`endif
    endfunction

    function automatic logic [PX_WIDTH-1:0] div2(input logic [W2-1:0] s);
`ifdef BILINEAR_DEMOSAICING_3X3_ROUND_EN
        return PX_WIDTH'((s + W2'(1)) >> 1);
`else
        return PX_WIDTH'(s >> 1);
`endif
    endfunction

    logic [PX_WIDTH-1:0] w_px [9];
    logic [W4-1:0]       w_x;
    logic [W4-1:0]       w_d;
    logic [W2-1:0]       w_h;
    logic [W2-1:0]       w_v;
    logic                w_in_hs;
    logic                w_s2_ready;
    site_e               w_site;
    logic                w_en;

    logic                r_s1_valid;
    logic [W4-1:0]       r_s1_x;
    logic [W4-1:0]       r_s1_d;
    logic [W2-1:0]       r_s1_h;
    logic [W2-1:0]       r_s1_v;
    logic [PX_WIDTH-1:0] r_s1_c;
    site_e               r_s1_site;
    logic                r_s1_en;
    logic                r_s1_tuser;
    logic                r_s1_tlast;

    logic [PX_WIDTH-1:0] w_r;
    logic [PX_WIDTH-1:0] w_g;
    logic [PX_WIDTH-1:0] w_b;

    logic                r_s2_valid;
    logic [3*PX_WIDTH-1:0] r_s2_rgb;
    logic                r_s2_tuser;
    logic                r_s2_tlast;

    // Valid/ready: a beat moves on valid && ready; a stage loads whenever it is
    // empty or its contents leave on the same edge, so a full pipe streams 1/clk.
    assign w_s2_ready   = !r_s2_valid || rgb_tready_i;
    assign win_tready_o = !r_s1_valid || w_s2_ready;
    assign w_in_hs      = win_tvalid_i && win_tready_o;

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            w_px[k] = win_tdata_i[k*PX_WIDTH +: PX_WIDTH];
        end
    end

    assign w_x = W4'(w_px[K_N])  + W4'(w_px[K_W])  + W4'(w_px[K_E])  + W4'(w_px[K_S]);
    assign w_d = W4'(w_px[K_NW]) + W4'(w_px[K_NE]) + W4'(w_px[K_SW]) + W4'(w_px[K_SE]);
    assign w_h = W2'(w_px[K_W])  + W2'(w_px[K_E]);
    assign w_v = W2'(w_px[K_N])  + W2'(w_px[K_S]);

    bilinear_demosaicing_3x3_bayer_phase u_phase (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_hs      (w_in_hs),
        .i_tuser   (win_tuser_i),
        .i_tlast   (win_tlast_i),
        .i_en      (en_i),
        .i_pattern (pattern_i),
        .o_site    (w_site),
        .o_en      (w_en)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_d     <= '0;
            r_s1_h     <= '0;
            r_s1_v     <= '0;
            r_s1_c     <= '0;
            r_s1_site  <= SITE_R;
            r_s1_en    <= RST_EN;
            r_s1_tuser <= 1'b0;
            r_s1_tlast <= 1'b0;
        end else begin
            if (win_tready_o) begin
                r_s1_valid <= win_tvalid_i;
            end
            if (w_in_hs) begin
                r_s1_x     <= w_x;
                r_s1_d     <= w_d;
                r_s1_h     <= w_h;
                r_s1_v     <= w_v;
                r_s1_c     <= w_px[K_CENTRE];
                r_s1_site  <= w_site;
                r_s1_en    <= w_en;
                r_s1_tuser <= win_tuser_i;
                r_s1_tlast <= win_tlast_i;
            end
        end
    end

    // Bypass (en latched low) leaves all three channels at the centre sample.
    always_comb begin
        w_r = r_s1_c;
        w_g = r_s1_c;
        w_b = r_s1_c;
        if (r_s1_en) begin
            case (r_s1_site)
                SITE_R: begin
                    w_g = div4(r_s1_x);
                    w_b = div4(r_s1_d);
                end
                SITE_B: begin
                    w_g = div4(r_s1_x);
                    w_r = div4(r_s1_d);
                end
                SITE_GR: begin
                    w_r = div2(r_s1_h);
                    w_b = div2(r_s1_v);
                end
                SITE_GB: begin
                    w_r = div2(r_s1_v);
                    w_b = div2(r_s1_h);
                end
                default: begin
                    w_r = r_s1_c;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s2_valid <= 1'b0;
            r_s2_rgb   <= '0;
            r_s2_tuser <= 1'b0;
            r_s2_tlast <= 1'b0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_rgb   <= {w_r, w_g, w_b};
                r_s2_tuser <= r_s1_tuser;
                r_s2_tlast <= r_s1_tlast;
            end
        end
    end

    assign rgb_tvalid_o = r_s2_valid;
    assign rgb_tdata_o  = r_s2_rgb;
    assign rgb_tuser_o  = r_s2_tuser;
    assign rgb_tlast_o  = r_s2_tlast;

endmodule

// File: tb/tb_bilinear_demosaicing_3x3_interp.sv
// Bench for bilinear_demosaicing_3x3_interp: directed and random windows against
// a position-based Bayer reference model, with random output backpressure.
module tb_bilinear_demosaicing_3x3_interp;

    localparam int PX = 10;
    localparam int WW = 9 * PX;
    localparam int OW = 3 * PX + 2;
`ifdef BILINEAR_DEMOSAICING_3X3_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            en_i;
    logic [1:0]      pattern_i;
    logic [WW-1:0]   win_tdata_i;
    logic            win_tvalid_i;
    logic            win_tready_o;
    logic            win_tuser_i;
    logic            win_tlast_i;
    logic [3*PX-1:0] rgb_tdata_o;
    logic            rgb_tvalid_o;
    logic            rgb_tready_i;
    logic            rgb_tuser_o;
    logic            rgb_tlast_o;

    bilinear_demosaicing_3x3_interp #(.PX_WIDTH(PX)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .pattern_i    (pattern_i),
        .win_tdata_i  (win_tdata_i),
        .win_tvalid_i (win_tvalid_i),
        .win_tready_o (win_tready_o),
        .win_tuser_i  (win_tuser_i),
        .win_tlast_i  (win_tlast_i),
        .rgb_tdata_o  (rgb_tdata_o),
        .rgb_tvalid_o (rgb_tvalid_o),
        .rgb_tready_i (rgb_tready_i),
        .rgb_tuser_o  (rgb_tuser_o),
        .rgb_tlast_o  (rgb_tlast_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int              checks = 0;
    int              errors = 0;
    logic [OW-1:0]   exp_q[$];
    int              rx_count = 0;
    int              ready_mode = 0;   // 0 always ready, 1 random 50%, 2 held low

    // reference model: control latched at frame start, pixel position in frame
    bit              m_en;
    bit [1:0]        m_pat;
    int              m_row;
    int              m_col;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int q4(input int s);
        return (s + 2 * RND) / 4;
    endfunction

    function automatic int q2(input int s);
        return (s + RND) / 2;
    endfunction

    function automatic logic [3*PX-1:0] ref_rgb(input logic [WW-1:0] w, input bit en,
                                                input bit [1:0] pat, input int row, input int col);
        int k[9];
        int c, x, d, h, v, r, g, b;
        bit red_row_site, red_col_site;
        for (int i = 0; i < 9; i++) k[i] = int'(w[i*PX +: PX]);
        c = k[4];
        x = k[1] + k[3] + k[5] + k[7];
        d = k[0] + k[2] + k[6] + k[8];
        h = k[3] + k[5];
        v = k[1] + k[7];
        red_row_site = ((row % 2) != 0) ^ pat[1];
        red_col_site = ((col % 2) != 0) ^ pat[0];
        r = c; g = c; b = c;
        if (en) begin
            if (!red_row_site && !red_col_site) begin
                g = q4(x); b = q4(d);
            end else if (red_row_site && red_col_site) begin
                g = q4(x); r = q4(d);
            end else if (!red_row_site) begin
                r = q2(h); b = q2(v);
            end else begin
                r = q2(v); b = q2(h);
            end
        end
        return {r[PX-1:0], g[PX-1:0], b[PX-1:0]};
    endfunction

    function automatic logic [WW-1:0] pack(input int k[9]);
        logic [WW-1:0] w;
        for (int i = 0; i < 9; i++) w[i*PX +: PX] = k[i][PX-1:0];
        return w;
    endfunction

    function automatic logic [WW-1:0] rand_win();
        logic [WW-1:0] w;
        for (int i = 0; i < 9; i++) w[i*PX +: PX] = PX'($urandom_range(0, (1 << PX) - 1));
        return w;
    endfunction

    task automatic model_reset();
        m_en  = 1'b1;
        m_pat = 2'd3;
        m_row = 0;
        m_col = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [WW-1:0] w, input logic u, input logic l,
                        input logic use_c, input logic [3*PX-1:0] c_rgb);
        int n;
        logic [3*PX-1:0] e;
        @(negedge clk_i);
        win_tdata_i  = w;
        win_tuser_i  = u;
        win_tlast_i  = l;
        win_tvalid_i = 1'b1;
        #1;
        n = 0;
        while (!win_tready_o && n < 1000) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        if (n >= 1000) begin
            chk("send_ready", win_tready_o, 1);
            win_tvalid_i = 1'b0;
        end else begin
            if (u) begin
                m_en  = en_i;
                m_pat = pattern_i;
                m_row = 0;
                m_col = 0;
            end
            e = use_c ? c_rgb : ref_rgb(w, m_en, m_pat, m_row, m_col);
            exp_q.push_back({e, u, l});
            if (l) begin
                m_row++;
                m_col = 0;
            end else begin
                m_col++;
            end
            @(posedge clk_i);
        end
    endtask

    task automatic drain();
        int n;
        @(negedge clk_i);
        win_tvalid_i = 1'b0;
        win_tuser_i  = 1'b0;
        win_tlast_i  = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        @(negedge clk_i);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- output ready driver ----------------
    always @(negedge clk_i) begin
        case (ready_mode)
            0:       rgb_tready_i <= 1'b1;
            1:       rgb_tready_i <= 1'($urandom_range(0, 1));
            default: rgb_tready_i <= 1'b0;
        endcase
    end

    // ---------------- output monitor ----------------
    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_out;
    logic [OW-1:0] mon_e;

    always @(negedge clk_i) begin
        #3;
        if (rst_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {rgb_tvalid_o, rgb_tdata_o, rgb_tuser_o, rgb_tlast_o}, {1'b1, prev_out});
            if (rgb_tvalid_o && rgb_tready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", rgb_tvalid_o, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rgb_out", {rgb_tdata_o, rgb_tuser_o, rgb_tlast_o}, mon_e);
                    rx_count++;
                end
            end
            prev_stall = rgb_tvalid_o && !rgb_tready_i;
            prev_out   = {rgb_tdata_o, rgb_tuser_o, rgb_tlast_o};
        end
    end

    // ---------------- directed sequence ----------------
    int kw[9];
    int base;

    initial begin
        rst_i        = 1'b1;
        en_i         = 1'b1;
        pattern_i    = 2'd0;
        win_tdata_i  = '0;
        win_tvalid_i = 1'b0;
        win_tuser_i  = 1'b0;
        win_tlast_i  = 1'b0;
        rgb_tready_i = 1'b1;
        model_reset();

        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_tvalid", rgb_tvalid_o, 0);
        chk("rst_tdata", rgb_tdata_o, 0);
        chk("rst_tuser", rgb_tuser_o, 0);
        chk("rst_tlast", rgb_tlast_o, 0);
        chk("rst_tready", win_tready_o, 1);
        @(negedge clk_i);
        rst_i = 1'b0;

        // no tuser after reset: latched defaults en=1, pattern=BGGR apply
        en_i = 1'b0;
        pattern_i = 2'd0;
        send(rand_win(), 1'b0, 1'b1, 1'b0, '0);
        send(rand_win(), 1'b0, 1'b0, 1'b0, '0);
        drain();
        en_i = 1'b1;

        // flat windows, all patterns, with two-cycle latency
        for (int p = 0; p < 4; p++) begin
            pattern_i = 2'(p);
            for (int i = 0; i < 9; i++) kw[i] = 100;
            send(pack(kw), 1'b1, 1'b1, 1'b1, {10'd100, 10'd100, 10'd100});
            @(negedge clk_i);
            win_tvalid_i = 1'b0;
            #1;
            chk("lat_cycle1_valid", rgb_tvalid_o, 0);
            @(negedge clk_i);
            #1;
            chk("lat_cycle2_valid", rgb_tvalid_o, 1);
            drain();
        end

        // R site then Gr site, RGGB
        pattern_i = 2'd0;
        kw = '{0, 200, 0, 200, 400, 200, 0, 200, 0};
        send(pack(kw), 1'b1, 1'b0, 1'b1, {10'd400, 10'd200, 10'd0});
        kw = '{0, 100, 0, 300, 500, 300, 0, 100, 0};
        send(pack(kw), 1'b0, 1'b1, 1'b1, {10'd300, 10'd500, 10'd100});
        drain();

        // rounding boundary: cross sum 3 at an R site
        kw = '{0, 1, 0, 1, 7, 1, 0, 0, 0};
        send(pack(kw), 1'b1, 1'b1, 1'b1, {10'd7, 10'(RND), 10'd0});
        drain();

        // 4x4 frame, BGGR
        pattern_i = 2'd3;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                send(rand_win(), (r == 0 && c == 0), (c == 3), 1'b0, '0);
        drain();

        // en dropped mid-frame is ignored; the next frame bypasses
        pattern_i = 2'd1;
        en_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) en_i = 1'b0;
            send(rand_win(), (i == 0), (i % 4 == 3), 1'b0, '0);
        end
        for (int i = 0; i < 8; i++) send(rand_win(), (i == 0), (i % 4 == 3), 1'b0, '0);
        drain();
        kw = '{1, 2, 3, 4, 321, 6, 7, 8, 9};
        send(pack(kw), 1'b1, 1'b1, 1'b1, {10'd321, 10'd321, 10'd321});
        drain();
        en_i = 1'b1;

        // random stream with random backpressure and a hard stall
        base = rx_count;
        @(posedge clk_i);
        ready_mode = 1;
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    if (i % 16 == 0) pattern_i = 2'($urandom_range(0, 3));
                    send(rand_win(), (i % 16 == 0), (i % 4 == 3), 1'b0, '0);
                end
            end
            begin
                repeat (20) @(posedge clk_i);
                ready_mode = 2;
                @(negedge clk_i);
                #1;
                repeat (2) @(posedge clk_i);
                @(negedge clk_i);
                #1;
                chk("stall_tready_low", win_tready_o, 0);
                repeat (3) @(posedge clk_i);
                ready_mode = 1;
            end
        join
        drain();
        @(posedge clk_i);
        ready_mode = 0;
        chk("stream_count", rx_count - base, 64);

        // reset mid-frame with data held in the pipeline
        @(posedge clk_i);
        ready_mode = 2;
        pattern_i = 2'd0;
        send(rand_win(), 1'b1, 1'b0, 1'b0, '0);
        send(rand_win(), 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk_i);
        rst_i = 1'b1;
        win_tvalid_i = 1'b0;
        exp_q.delete();
        ready_mode = 0;
        #1;
        chk("midrst_tvalid", rgb_tvalid_o, 0);
        chk("midrst_tdata", rgb_tdata_o, 0);
        chk("midrst_tready", win_tready_o, 1);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        send(rand_win(), 1'b0, 1'b0, 1'b0, '0);
        pattern_i = 2'd2;
        for (int i = 0; i < 8; i++) send(rand_win(), (i == 0), (i % 4 == 3), 1'b0, '0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
